nvdla_csb_sequencer: RTL
========================

# nvdla_csb_sequencer

Sequences register accesses from the HWPE control side onto the NVDLA CSB port. One command is in flight at a time. The block sits directly upstream of the NVDLA engine's CSB interface: it owns the csb2nvdla valid/ready handshake and waits for read data or write completion. It returns exactly one response beat per command, which carries timeout-based error reporting.

## Interface
- ADDR_W, 16, CSB address width
- DATA_W, 32, CSB write/read data width
- TIMEOUT, 1024, cycles allowed per phase (request or response) before error; must be ≥ 2
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous soft clear
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_addr_i  in  ADDR_W  register address
- cmd_wdat_i  in  DATA_W  write data
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_nposted_i  in  1  write expects wr_complete (ignored for reads)
- csb_valid_o  out  1  csb2nvdla_valid
- csb_ready_i  in  1  csb2nvdla_ready
- csb_addr_o / csb_wdat_o / csb_write_o / csb_nposted_o  out  ADDR_W/DATA_W/1/1  registered command fields
- csb_rvalid_i  in  1  nvdla2csb_valid
- csb_rdata_i  in  DATA_W  nvdla2csb_data
- csb_wr_complete_i  in  1  nvdla2csb_wr_complete
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  DATA_W  read data (0 for writes and errors)
- rsp_err_o  out  2  00 ok, 01 request timeout, 10 response timeout
- rsp_write_o  out  1  echo of command type
- busy_o  out  1  state ≠ IDLE
- done_cnt_o  out  16  responses delivered, wraps
- spurious_cnt_o  out  8  unexpected CSB responses, saturates at 255

## Operation
- States: IDLE, REQ, WAIT_RD, WAIT_WR, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, latch the command fields into the csb_* registers, clear the timer, and go to REQ.
- REQ:
  - csb_valid_o = 1; csb_* are held stable.
  - On csb_ready_i, select the next state:
    - read → WAIT_RD;
    - non-posted write → WAIT_WR;
    - posted write → RESP with err 00.
  - If the required response input is already high in the handshake cycle (csb_rvalid_i for a read, csb_wr_complete_i for a non-posted write), go directly to RESP with err 00. rsp_data_o takes csb_rdata_i for a read.
  - If the timer reaches TIMEOUT-1 without csb_ready_i, go to RESP with err 01. csb_valid_o drops.
- WAIT_RD:
  - On csb_rvalid_i, capture csb_rdata_i and go to RESP with err 00.
  - If the timer reaches TIMEOUT-1 first, go to RESP with err 10 and data 0.
- WAIT_WR:
  - On csb_wr_complete_i, go to RESP with err 00.
  - If the timer reaches TIMEOUT-1 first, go to RESP with err 10.
- RESP:
  - rsp_valid_o = 1; all rsp_* fields are held stable.
  - On rsp_ready_i, increment done_cnt_o and return to IDLE.
  - A new command is not accepted in the same cycle.
- Timer:
  - 0 on state entry; +1 per cycle in REQ, WAIT_RD and WAIT_WR.
  - Width is $clog2(TIMEOUT).
  - Expiry and a valid response in the same cycle: the response wins, err 00.
- Spurious responses:
  - csb_rvalid_i or csb_wr_complete_i high while not expected increments spurious_cnt_o by 1 per cycle.
  - Not expected means: any state other than the matching wait state, or the REQ handshake cycle of a matching command.
  - Both inputs spurious in the same cycle: +1 only.
- clear_i:
  - Forces IDLE.
  - Zeroes the timer, done_cnt_o and spurious_cnt_o.
  - Deasserts csb_valid_o and rsp_valid_o the next cycle.
  - Any in-flight command is dropped.
  - clear_i takes priority over all other events.
- Reset mid-operation: identical to clear_i, but asynchronous.

## Timing
- Reset values:
  - state IDLE, cmd_ready_o 1, csb_valid_o 0, rsp_valid_o 0, busy_o 0;
  - all csb_* and rsp_* data fields 0;
  - both counters 0.
- Outputs are registered except cmd_ready_o and busy_o, which are decoded from state.
- Cycle numbering: command accepted at edge 0.
  - csb_valid_o is high from cycle 1.
  - With csb_ready_i high in cycle 1 and the response in cycle 2, rsp_valid_o is high in cycle 3.
- Posted write with immediate ready: rsp_valid_o in cycle 2.
- Minimum command-to-command spacing: 3 cycles (IDLE, REQ, RESP).
- Request timeout: rsp_valid_o rises TIMEOUT cycles after REQ entry.

## Test plan
- Read, addr 0x0010: csb_ready_i in cycle 1, csb_rvalid_i with data 0xCAFEF00D in cycle 4 → rsp_data_o 0xCAFEF00D, err 00, done_cnt_o 1.
- Posted write 0x1234 → 0x0020: csb_ready_i held high → csb_valid_o for exactly 1 cycle, rsp_valid_o in cycle 2, rsp_write_o 1, err 00.
- Non-posted write, csb_wr_complete_i never asserted, TIMEOUT=16 → err 10, rsp_data_o 0, busy_o low after rsp_ready_i.
- csb_ready_i held low, TIMEOUT=16 → rsp_valid_o at cycle 17 with err 01; csb_valid_o low from cycle 17.
- csb_rvalid_i pulsed 3 times while IDLE, then clear_i → spurious_cnt_o 3, then 0 after clear.
- rsp_ready_i held low 10 cycles with cmd_valid_i high → cmd_ready_o stays 0; response fields stable; second command accepted the cycle after the rsp handshake.

Source files
------------

// File: rtl/nvdla_csb_sequencer_if.sv
// Command, CSB and response bundle of the NVDLA CSB sequencer.
// slave = sequencer side, master = control side plus NVDLA model.
interface nvdla_csb_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdat_i;
    logic              cmd_write_i;
    logic              cmd_nposted_i;

    logic              csb_valid_o;
    logic              csb_ready_i;
    logic [ADDR_W-1:0] csb_addr_o;
    logic [DATA_W-1:0] csb_wdat_o;
    logic              csb_write_o;
    logic              csb_nposted_o;
    logic              csb_rvalid_i;
    logic [DATA_W-1:0] csb_rdata_i;
    logic              csb_wr_complete_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic [1:0]        rsp_err_o;
    logic              rsp_write_o;

    modport slave (
        input  cmd_valid_i, cmd_addr_i, cmd_wdat_i,
        input  cmd_write_i, cmd_nposted_i,
        output cmd_ready_o,
        output csb_valid_o, csb_addr_o, csb_wdat_o,
        output csb_write_o, csb_nposted_o,
        input  csb_ready_i, csb_rvalid_i, csb_rdata_i,
        input  csb_wr_complete_i,
        output rsp_valid_o, rsp_data_o, rsp_err_o, rsp_write_o,
        input  rsp_ready_i
    );

    modport master (
        output cmd_valid_i, cmd_addr_i, cmd_wdat_i,
        output cmd_write_i, cmd_nposted_i,
        input  cmd_ready_o,
        input  csb_valid_o, csb_addr_o, csb_wdat_o,
        input  csb_write_o, csb_nposted_o,
        output csb_ready_i, csb_rvalid_i, csb_rdata_i,
        output csb_wr_complete_i,
        input  rsp_valid_o, rsp_data_o, rsp_err_o, rsp_write_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/nvdla_csb_sequencer.sv
// Single-outstanding CSB register access sequencer with
// per-phase timeout and spurious-response counting.
module nvdla_csb_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    nvdla_csb_sequencer_if.slave  bus,
    output logic                  busy_o,
    output logic [15:0]           done_cnt_o,
    output logic [7:0]            spurious_cnt_o
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT_RD, WAIT_WR, RESP
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              csb_valid_q, csb_valid_d;
    logic [ADDR_W-1:0] csb_addr_q;
    logic [DATA_W-1:0] csb_wdat_q;
    logic              csb_write_q, csb_nposted_q;
    logic              ld_cmd;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_err_q, rsp_err_d;
    logic              rsp_write_q, rsp_write_d;
    logic [15:0]       done_q, done_d;
    logic [7:0]        spur_q, spur_d;
    logic              expired;
    logic              hs;
    logic              rd_exp, wr_exp, spur;

    assign expired = (timer_q == TW'(TIMEOUT - 1));
    assign hs      = (state_q == REQ) && bus.csb_ready_i;

    // A response is expected only in its wait state or in the
    // request handshake cycle of a command that asks for it.
    assign rd_exp = (state_q == WAIT_RD) || (hs && !csb_write_q);
    assign wr_exp = (state_q == WAIT_WR)
                 || (hs && csb_write_q && csb_nposted_q);
    assign spur   = (bus.csb_rvalid_i && !rd_exp)
                 || (bus.csb_wr_complete_i && !wr_exp);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        csb_valid_d = csb_valid_q;
        ld_cmd      = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_write_d = rsp_write_q;
        done_d      = done_q;
        spur_d      = spur_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    ld_cmd      = 1'b1;
                    timer_d     = '0;
                    csb_valid_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus.csb_ready_i) begin
                    csb_valid_d = 1'b0;
                    timer_d     = '0;
                    if (!csb_write_q) begin
                        if (bus.csb_rvalid_i) begin
                            state_d     = RESP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 2'b00;
                            rsp_data_d  = bus.csb_rdata_i;
                            rsp_write_d = csb_write_q;
                        end else begin
                            state_d = WAIT_RD;
                        end
                    end else if (csb_nposted_q
                              && !bus.csb_wr_complete_i) begin
                        state_d = WAIT_WR;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 2'b00;
                        rsp_data_d  = '0;
                        rsp_write_d = csb_write_q;
                    end
                end else if (expired) begin
                    csb_valid_d = 1'b0;
                    timer_d     = '0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 2'b01;
                    rsp_data_d  = '0;
                    rsp_write_d = csb_write_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_RD: begin
                if (bus.csb_rvalid_i || expired) begin
                    timer_d     = '0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = csb_write_q;
                    rsp_err_d   = bus.csb_rvalid_i ? 2'b00 : 2'b10;
                    rsp_data_d  = bus.csb_rvalid_i ? bus.csb_rdata_i
                                                   : '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_WR: begin
                if (bus.csb_wr_complete_i || expired) begin
                    timer_d     = '0;
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = csb_write_q;
                    rsp_data_d  = '0;
                    rsp_err_d   = bus.csb_wr_complete_i ? 2'b00
                                                        : 2'b10;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    done_d      = done_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (spur && (spur_q != 8'hFF)) begin
            spur_d = spur_q + 8'd1;
        end

        if (clear_i) begin
            state_d     = IDLE;
            timer_d     = '0;
            csb_valid_d = 1'b0;
            rsp_valid_d = 1'b0;
            ld_cmd      = 1'b0;
            done_d      = '0;
            spur_d      = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            csb_valid_q   <= 1'b0;
            csb_addr_q    <= '0;
            csb_wdat_q    <= '0;
            csb_write_q   <= 1'b0;
            csb_nposted_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 2'b00;
            rsp_write_q   <= 1'b0;
            done_q        <= '0;
            spur_q        <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            csb_valid_q <= csb_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_write_q <= rsp_write_d;
            done_q      <= done_d;
            spur_q      <= spur_d;
            if (ld_cmd) begin
                csb_addr_q    <= bus.cmd_addr_i;
                csb_wdat_q    <= bus.cmd_wdat_i;
                csb_write_q   <= bus.cmd_write_i;
                csb_nposted_q <= bus.cmd_nposted_i;
            end
        end
    end

    assign bus.cmd_ready_o   = (state_q == IDLE);
    assign busy_o            = (state_q != IDLE);
    assign bus.csb_valid_o   = csb_valid_q;
    assign bus.csb_addr_o    = csb_addr_q;
    assign bus.csb_wdat_o    = csb_wdat_q;
    assign bus.csb_write_o   = csb_write_q;
    assign bus.csb_nposted_o = csb_nposted_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_data_o    = rsp_data_q;
    assign bus.rsp_err_o     = rsp_err_q;
    assign bus.rsp_write_o   = rsp_write_q;
    assign done_cnt_o        = done_q;
    assign spurious_cnt_o    = spur_q;
endmodule
